// File: rtl/tx_ep_arb.sv
// tx_ep_arb: arbitrates the shared TRN transmit interface between two requesters; macro TAG_CREDIT_EN adds tag credit gating
module tx_ep_arb #(
    parameter logic [63:0] IDLE_TD  = 64'h0,
    parameter int          WDOG_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic [63:0] r0_td,
    input  logic [63:0] r1_td,
    input  logic [7:0]  r0_trem_n,
    input  logic [7:0]  r1_trem_n,
    input  logic        r0_tsof_n,
    input  logic        r1_tsof_n,
    input  logic        r0_teof_n,
    input  logic        r1_teof_n,
    input  logic        r0_tsrc_rdy_n,
    input  logic        r1_tsrc_rdy_n,
    input  logic        r0_req_ep,
    input  logic        r1_req_ep,
    input  logic        r0_drv_ep,
    input  logic        r1_drv_ep,
    input  logic        r0_tag_inc,
    input  logic        r1_tag_inc,
`ifdef TAG_CREDIT_EN
    input  logic        cpl_tag_rel,
    output logic        tags_full,
`endif
    output logic        r0_my_trn,
    output logic        r1_my_trn,
    output logic [4:0]  tag_trn,
    output logic        arb_busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GNT0  = 3'd1;
    localparam logic [2:0] S_GNT1  = 3'd2;
    localparam logic [2:0] S_BUSY0 = 3'd3;
    localparam logic [2:0] S_BUSY1 = 3'd4;

    logic [2:0] r_state;
    logic       r_last;
    logic [7:0] r_wdog;
    logic [4:0] r_tag;
    logic       w_req0;
    logic       w_own1;
    logic       w_drv;
    logic       w_req;

`ifdef TAG_CREDIT_EN
    logic [5:0] r_out;
    logic [6:0] w_sum;
    logic [6:0] w_next;

    assign w_sum  = 7'(r_out) + 7'(r0_tag_inc) + 7'(r1_tag_inc);
    assign w_next = (cpl_tag_rel && w_sum != 7'd0) ? w_sum - 7'd1 : w_sum;

    // outstanding read tags, saturating at 32 so a runaway requester cannot wrap it
    always_ff @(posedge clk) begin
        r_out <= rst ? 6'd0 : (w_next > 7'd32 ? 6'd32 : w_next[5:0]);
    end

    assign tags_full = r_out == 6'd32;
    assign w_req0    = r0_req_ep & ~tags_full;
`else
    assign w_req0 = r0_req_ep;
`endif

    // select the current owner's handshake for the grant/busy exits
    always_comb begin
        w_own1 = r_state == S_GNT1 || r_state == S_BUSY1;
        w_drv  = w_own1 ? r1_drv_ep : r0_drv_ep;
        w_req  = w_own1 ? r1_req_ep : r0_req_ep;
    end

    // grant FSM: round-robin on ties, watchdog revokes an abandoned grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_wdog  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wdog <= 8'd0;
                    if (w_req0 && (!r1_req_ep || r_last))
                        r_state <= S_GNT0;
                    else if (r1_req_ep)
                        r_state <= S_GNT1;
                end
                S_GNT0, S_GNT1: begin
                    if (w_drv)
                        r_state <= w_own1 ? S_BUSY1 : S_BUSY0;
                    else if (w_req)
                        r_wdog <= 8'd0;
                    else if (r_wdog == 8'(WDOG_CYC - 1))
                        r_state <= S_IDLE;
                    else
                        r_wdog <= r_wdog + 8'd1;
                end
                S_BUSY0, S_BUSY1: begin
                    if (!w_drv) begin
                        r_state <= S_IDLE;
                        r_last  <= w_own1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // shared read tag counter; both requesters may consume a tag in one cycle
    always_ff @(posedge clk) begin
        r_tag <= rst ? 5'd0 : r_tag + 5'(r0_tag_inc) + 5'(r1_tag_inc);
    end

    // zero-latency TRN mux following drv_ep, requester 0 first
    always_comb begin
        trn_td         = r0_drv_ep ? r0_td         : r1_drv_ep ? r1_td         : IDLE_TD;
        trn_trem_n     = r0_drv_ep ? r0_trem_n     : r1_drv_ep ? r1_trem_n     : 8'hFF;
        trn_tsof_n     = r0_drv_ep ? r0_tsof_n     : r1_drv_ep ? r1_tsof_n     : 1'b1;
        trn_teof_n     = r0_drv_ep ? r0_teof_n     : r1_drv_ep ? r1_teof_n     : 1'b1;
        trn_tsrc_rdy_n = r0_drv_ep ? r0_tsrc_rdy_n : r1_drv_ep ? r1_tsrc_rdy_n : 1'b1;
    end

    assign r0_my_trn = r_state == S_GNT0 || r_state == S_BUSY0;
    assign r1_my_trn = r_state == S_GNT1 || r_state == S_BUSY1;
    assign tag_trn   = r_tag;
    assign arb_busy  = r_state != S_IDLE;
endmodule

// File: tb/tb_tx_ep_arb.sv
// tb_tx_ep_arb: scoreboard bench for tx_ep_arb; build with TAG_CREDIT_EN to exercise tag credit gating
module tb_tx_ep_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic [63:0] r0_td, r1_td;
    logic [7:0]  r0_trem_n, r1_trem_n;
    logic        r0_tsof_n, r1_tsof_n, r0_teof_n, r1_teof_n;
    logic        r0_tsrc_rdy_n, r1_tsrc_rdy_n;
    logic        r0_req_ep, r1_req_ep, r0_drv_ep, r1_drv_ep;
    logic        r0_tag_inc, r1_tag_inc;
    logic        r0_my_trn, r1_my_trn;
    logic [4:0]  tag_trn;
    logic        arb_busy;
`ifdef TAG_CREDIT_EN
    logic        cpl_tag_rel;
    logic        tags_full;
    int          out_m = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [1:0]  mon_g, prev_g;
    logic [4:0]  prev_tag;
    logic [4:0]  tag_m = 5'd0;
    logic [73:0] q_beat[$];
    logic [1:0]  q_gv[$];
    int          q_gc[$];
    logic [4:0]  q_tag[$];

    tx_ep_arb #(.IDLE_TD(64'h0), .WDOG_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .r0_td(r0_td), .r1_td(r1_td), .r0_trem_n(r0_trem_n), .r1_trem_n(r1_trem_n),
        .r0_tsof_n(r0_tsof_n), .r1_tsof_n(r1_tsof_n), .r0_teof_n(r0_teof_n), .r1_teof_n(r1_teof_n),
        .r0_tsrc_rdy_n(r0_tsrc_rdy_n), .r1_tsrc_rdy_n(r1_tsrc_rdy_n),
        .r0_req_ep(r0_req_ep), .r1_req_ep(r1_req_ep), .r0_drv_ep(r0_drv_ep), .r1_drv_ep(r1_drv_ep),
        .r0_tag_inc(r0_tag_inc), .r1_tag_inc(r1_tag_inc),
`ifdef TAG_CREDIT_EN
        .cpl_tag_rel(cpl_tag_rel), .tags_full(tags_full),
`endif
        .r0_my_trn(r0_my_trn), .r1_my_trn(r1_my_trn), .tag_trn(tag_trn), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic [1:0] g, input int c);
        q_gv.push_back(g);
        q_gc.push_back(c);
    endtask

    task automatic drive(input bit n, input logic drv, input logic [63:0] td, input logic [7:0] trem,
                         input logic sof, input logic eof, input logic rdy);
        if (n) begin
            r1_drv_ep = drv; r1_req_ep = 1'b0; r1_td = td; r1_trem_n = trem;
            r1_tsof_n = sof; r1_teof_n = eof; r1_tsrc_rdy_n = rdy;
        end else begin
            r0_drv_ep = drv; r0_req_ep = 1'b0; r0_td = td; r0_trem_n = trem;
            r0_tsof_n = sof; r0_teof_n = eof; r0_tsrc_rdy_n = rdy;
        end
    endtask

    // three-beat TLP from requester n, starting in the cycle its grant is visible
    task automatic send(input bit n, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [7:0] tl);
        logic [63:0] d[3];
        logic [7:0]  trem;
        d = '{d0, d1, d2};
        for (int i = 0; i < 3; i++) begin
            trem = (i == 2) ? tl : 8'h00;
            drive(n, 1'b1, d[i], trem, i != 0, i != 2, 1'b0);
            q_beat.push_back({d[i], trem, i != 0, i != 2});
            tick;
        end
        drive(n, 1'b0, 64'hDEAD_BEEF_0000_0001, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_gnt(2'b00, cyc + 1);
    endtask

    task automatic tag_pulse(input logic a, input logic b);
        r0_tag_inc = a;
        r1_tag_inc = b;
        tag_m = tag_m + 5'(a) + 5'(b);
`ifdef TAG_CREDIT_EN
        out_m = (out_m + int'(a) + int'(b) > 32) ? 32 : out_m + int'(a) + int'(b);
`endif
        if (a || b) q_tag.push_back(tag_m);
        tick;
        r0_tag_inc = 1'b0;
        r1_tag_inc = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a grant change, beat or tag change
    always @(negedge clk) begin
        mon_g = {r1_my_trn, r0_my_trn};
        if (!mon_en) begin
            prev_g   = mon_g;
            prev_tag = tag_trn;
        end else begin
            assert (!(r0_drv_ep && r1_drv_ep)) else $error("both drv_ep high");
            if (mon_g != prev_g) begin
                if (q_gv.size() == 0) chk("gnt_unexpected", mon_g, prev_g);
                else begin
                    chk("gnt_val", mon_g, q_gv.pop_front());
                    chk("gnt_cyc", cyc, q_gc.pop_front());
                end
                prev_g = mon_g;
            end
            chk("arb_busy", arb_busy, r0_my_trn | r1_my_trn);
            if (!trn_tsrc_rdy_n) begin
                if (q_beat.size() == 0) chk("beat_unexpected", trn_tsrc_rdy_n, 1'b1);
                else chk("beat", {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n}, q_beat.pop_front());
            end
            if (!r0_drv_ep && !r1_drv_ep)
                chk("idle_mux", {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n},
                    {64'h0, 8'hFF, 3'b111});
            if (tag_trn != prev_tag) begin
                if (q_tag.size() == 0) chk("tag_unexpected", tag_trn, prev_tag);
                else chk("tag", tag_trn, q_tag.pop_front());
                prev_tag = tag_trn;
            end
        end
    end

    initial begin
        rst = 1'b1;
        {r0_td, r1_td} = '0;
        {r0_trem_n, r1_trem_n} = '1;
        {r0_tsof_n, r1_tsof_n, r0_teof_n, r1_teof_n, r0_tsrc_rdy_n, r1_tsrc_rdy_n} = '1;
        {r0_req_ep, r1_req_ep, r0_drv_ep, r1_drv_ep, r0_tag_inc, r1_tag_inc} = '0;
`ifdef TAG_CREDIT_EN
        cpl_tag_rel = 1'b0;
`endif
        repeat (3) tick;
        chk("rst_my_trn", {r1_my_trn, r0_my_trn}, 2'b00);
        chk("rst_tag", tag_trn, 5'd0);
        chk("rst_busy", arb_busy, 1'b0);
`ifdef TAG_CREDIT_EN
        chk("rst_full", tags_full, 1'b0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;
        tick;
        // simultaneous requests: r0 wins first tie, r1 follows after one idle cycle
        r0_req_ep = 1'b1;
        r1_req_ep = 1'b1;
        exp_gnt(2'b01, cyc + 1);
        tick;
        send(1'b0, 64'h1111_0000_0000_0001, 64'h1111_0000_0000_0002, 64'h1111_0000_0000_0003, 8'h00);
        exp_gnt(2'b10, cyc + 2);
        repeat (2) tick;
        send(1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h1, 64'h2, 8'h0F);
        tick;
        // watchdog: r0 abandons its grant while r1 waits
        r0_req_ep = 1'b1;
        exp_gnt(2'b01, cyc + 1);
        tick;
        r0_req_ep = 1'b0;
        r1_req_ep = 1'b1;
        exp_gnt(2'b00, cyc + 16);
        exp_gnt(2'b10, cyc + 17);
        repeat (17) tick;
        send(1'b1, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002, 64'h3333_0000_0000_0003, 8'hF0);
        tick;
        // tag counter wrap and dual increments
        for (int i = 0; i < 33; i++) tag_pulse(1'b1, 1'b0);
        chk("tag_wrap", tag_trn, 5'd1);
        for (int i = 0; i < 4; i++) tag_pulse(1'b1, 1'b0);
        tag_pulse(1'b1, 1'b1);
        tag_pulse(1'b0, 1'b1);
        tick;
`ifdef TAG_CREDIT_EN
        chk("tags_full_set", tags_full, out_m == 32);
        r0_req_ep = 1'b1;
        repeat (5) tick;
        cpl_tag_rel = 1'b1;
        out_m = out_m - 1;
        exp_gnt(2'b01, cyc + 2);
        tick;
        cpl_tag_rel = 1'b0;
        chk("tags_full_clr", tags_full, out_m == 32);
        tick;
        send(1'b0, 64'h4444_0000_0000_0001, 64'h4444_0000_0000_0002, 64'h4444_0000_0000_0003, 8'h00);
        tick;
`endif
        // reset in the middle of a TLP
        r0_req_ep = 1'b1;
        exp_gnt(2'b01, cyc + 1);
        tick;
        drive(1'b0, 1'b1, 64'h5555_0000_0000_0001, 8'h00, 1'b0, 1'b1, 1'b0);
        q_beat.push_back({64'h5555_0000_0000_0001, 8'h00, 1'b0, 1'b1});
        tick;
        q_beat.push_back({64'h5555_0000_0000_0001, 8'h00, 1'b0, 1'b1});
        rst = 1'b1;
        exp_gnt(2'b00, cyc + 1);
        tag_m = 5'd0;
        q_tag.push_back(tag_m);
        tick;
        drive(1'b0, 1'b0, 64'h0, 8'hFF, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        repeat (5) tick;
        chk("gnt_left", q_gv.size(), 0);
        chk("beat_left", q_beat.size(), 0);
        chk("tag_left", q_tag.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
